// File: rtl/traffic_gen_if.sv
// Valid/ready flit port between a traffic generator and its router.
interface traffic_gen_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             ready_in;

    modport master (output data_out, output valid_out, input ready_in);
    modport slave  (input data_out, input valid_out, output ready_in);
endinterface

// File: rtl/traffic_gen.sv
// Traffic pattern generator: streams NUM_PKTS single-flit packets
// {src, dst, id, counter} to one router port over valid/ready.
module traffic_gen #(
    parameter int         WIDTH        = 32,
    parameter int         N            = 16,
    parameter int         N_ADDR_WIDTH = $clog2(N),
    parameter logic [7:0] ID           = 8'd0,
    parameter int         NODE         = 0,
    parameter int         DEST         = 15,
    parameter int         NUM_PKTS     = 102,
    parameter int         GAP          = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          done,
    traffic_gen_if.master bus
);
    localparam int NAW = N_ADDR_WIDTH;
    localparam int DW  = WIDTH - 2 * NAW - 8;

    localparam logic [NAW-1:0] SRC_A = NAW'(NODE);
    localparam logic [NAW-1:0] DST_A = NAW'(DEST);
    localparam logic [31:0]    NPKT  = 32'(NUM_PKTS);
    localparam logic [31:0]    GAPL  = 32'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    cnt, cnt_n;
    logic [31:0]      sent, sent_n;
    logic [31:0]      gap, gap_n;
    logic             valid_q;
    logic             done_q;
    logic [WIDTH-1:0] data_q;
    logic             xfer;

    assign xfer          = valid_q & bus.ready_in;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign done          = done_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sent_n  = sent;
        gap_n   = gap;
        case (state)
            S_IDLE: begin
                if (NUM_PKTS == 0)
                    state_n = S_DONE;
                else if (enable)
                    state_n = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    cnt_n  = cnt + DW'(1);
                    sent_n = (sent < NPKT) ? sent + 32'd1 : sent;
                    if (sent_n == NPKT) begin
                        state_n = S_DONE;
                    end else if (GAP > 0) begin
                        state_n = S_GAP;
                        gap_n   = GAPL;
                    end else if (!enable) begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap == 32'd0)
                    state_n = enable ? S_SEND : S_IDLE;
                else
                    gap_n = gap - 32'd1;
            end
            S_DONE: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sent    <= '0;
            gap     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sent    <= sent_n;
            gap     <= gap_n;
            valid_q <= (state_n == S_SEND);
            done_q  <= (state_n == S_DONE);
            if (state_n == S_SEND)
                data_q <= {SRC_A, DST_A, ID, cnt_n};
        end
    end
endmodule
